// File: rtl/regfile32.sv
// ---------------------------------------------------------------------------
// regfile32 -- MIPS register file: 2**ADDR_W x DATA_W, one write port, two
// read ports, hardwired zero register, write-through bypass on reads.
//
// Parameters
//   DATA_W     register width
//   ADDR_W     register index width (depth = 2**ADDR_W)
//   SYNC_READ  0 = combinational read ports, 1 = registered read ports
//
// Ports
//   clock       rising-edge clock
//   reset       asynchronous, active-low; clears storage, read regs, counter
//   regWrite    write enable
//   writeReg    destination index (index 0 discards the write)
//   writeData   word to write
//   readReg1/2  read indices (rs / rt)
//   readEn      read strobe, registered mode only; low holds the outputs
//   readData1/2 read data
//   writeCount  saturating count of accepted writes (debug aid)
// ---------------------------------------------------------------------------
module regfile32 #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter bit SYNC_READ = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              regWrite,
  input  logic [ADDR_W-1:0] writeReg,
  input  logic [DATA_W-1:0] writeData,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  input  logic              readEn,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  output logic [15:0]       writeCount
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              write_en;
  logic [DATA_W-1:0] comb_rd1;
  logic [DATA_W-1:0] comb_rd2;

  // A write to register 0 is not a write at all: no storage change, no count.
  assign write_en = regWrite && (writeReg != '0);

  // NOTE: this array is reset because every register must read 0 after reset;
  // that forces it into flops rather than a RAM macro, which is acceptable at
  // 32 entries. Entry 0 is never written, so it stays a constant 0.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (write_en) begin
      regs[writeReg] <= writeData;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      writeCount <= '0;
    end else if (write_en && (writeCount != 16'hFFFF)) begin
      writeCount <= writeCount + 16'd1;
    end
  end

  // Combinational read value including same-cycle bypass. write_en already
  // excludes index 0, so the zero check only needs to cover the stored path.
  assign comb_rd1 = (readReg1 == '0)                       ? '0        :
                    (write_en && (writeReg == readReg1))   ? writeData :
                                                             regs[readReg1];
  assign comb_rd2 = (readReg2 == '0)                       ? '0        :
                    (write_en && (writeReg == readReg2))   ? writeData :
                                                             regs[readReg2];

  if (SYNC_READ) begin : g_sync_read
    logic [DATA_W-1:0] rd1_q;
    logic [DATA_W-1:0] rd2_q;

    // Capturing the bypassed value makes a write visible at the same edge
    // that performs it; readEn low freezes the outputs for an ID stall.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        rd1_q <= '0;
        rd2_q <= '0;
      end else if (readEn) begin
        rd1_q <= comb_rd1;
        rd2_q <= comb_rd2;
      end
    end

    assign readData1 = rd1_q;
    assign readData2 = rd2_q;
  end else begin : g_comb_read
    // readEn has no meaning for combinational ports.
    logic unused_read_en;
    assign unused_read_en = readEn;

    assign readData1 = comb_rd1;
    assign readData2 = comb_rd2;
  end

endmodule

// File: tb/tb_regfile32.sv
// ---------------------------------------------------------------------------
// tb_regfile32 -- directed bench for regfile32. One combinational-read and
// one registered-read instance share all inputs, so every vector checks both.
// ---------------------------------------------------------------------------
module tb_regfile32;

  logic        clock;
  logic        reset;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic [4:0]  readReg1;
  logic [4:0]  readReg2;
  logic        readEn;
  logic [31:0] c_rd1, c_rd2, s_rd1, s_rd2;
  logic [15:0] c_cnt, s_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  regfile32 #(.SYNC_READ(1'b0)) dut_comb (
    .clock(clock), .reset(reset), .regWrite(regWrite), .writeReg(writeReg),
    .writeData(writeData), .readReg1(readReg1), .readReg2(readReg2),
    .readEn(readEn), .readData1(c_rd1), .readData2(c_rd2), .writeCount(c_cnt)
  );

  regfile32 #(.SYNC_READ(1'b1)) dut_sync (
    .clock(clock), .reset(reset), .regWrite(regWrite), .writeReg(writeReg),
    .writeData(writeData), .readReg1(readReg1), .readReg2(readReg2),
    .readEn(readEn), .readData1(s_rd1), .readData2(s_rd2), .writeCount(s_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Ends 1 time unit after a rising edge so outputs are sampled off the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2);
    regWrite  = we;
    writeReg  = wa;
    writeData = wd;
    readReg1  = r1;
    readReg2  = r2;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    tick();
    reset = 1'b1;
  endtask

  initial begin
    logic [15:0] cnt_before;

    // Table: vectors start from a freshly reset file. Accepted writes: r5, r6, r31.
    vecs[0] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  32'h0,        32'h0};
    vecs[1] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd6,  32'hDEADBEEF, 32'h0};
    vecs[2] = '{1'b1, 5'd6,  32'h12345678, 5'd5,  5'd6,  32'hDEADBEEF, 32'h12345678};
    vecs[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
    vecs[4] = '{1'b0, 5'd6,  32'hAAAAAAAA, 5'd6,  5'd6,  32'h12345678, 32'h12345678};
    vecs[5] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0};
    vecs[6] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd30, 32'hCAFEF00D, 32'h0};
    vecs[7] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd5,  32'hCAFEF00D, 32'hDEADBEEF};

    reset  = 1'b0;
    readEn = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd31);
    #3;
    check("reset_comb_rd1", c_rd1, 32'h0);
    check("reset_comb_rd2", c_rd2, 32'h0);
    check("reset_sync_rd1", s_rd1, 32'h0);
    check("reset_cnt", {16'h0, c_cnt}, 32'h0);
    tick();
    tick();
    reset = 1'b1;

    // Table-driven pass: comb ports checked before the edge, sync ports after.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].r1, vecs[i].r2);
      #1;
      check($sformatf("vec%0d_comb_rd1", i), c_rd1, vecs[i].e1);
      check($sformatf("vec%0d_comb_rd2", i), c_rd2, vecs[i].e2);
      tick();
      check($sformatf("vec%0d_sync_rd1", i), s_rd1, vecs[i].e1);
      check($sformatf("vec%0d_sync_rd2", i), s_rd2, vecs[i].e2);
    end
    check("table_cnt_comb", {16'h0, c_cnt}, 32'd3);
    check("table_cnt_sync", {16'h0, s_cnt}, 32'd3);

    // Zero register: write to r0 leaves count unchanged and r0 reads 0.
    cnt_before = c_cnt;
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    #1;
    check("zero_rd1", c_rd1, 32'h0);
    check("zero_cnt", {16'h0, c_cnt}, {16'h0, cnt_before});

    // Asynchronous reset mid-cycle: r5 holds DEADBEEF, outputs clear without an edge.
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    #1;
    check("pre_reset_r5", c_rd1, 32'hDEADBEEF);
    #1;
    reset = 1'b0;
    #1;
    check("async_reset_comb_rd1", c_rd1, 32'h0);
    check("async_reset_sync_rd1", s_rd1, 32'h0);
    check("async_reset_cnt", {16'h0, c_cnt}, 32'h0);
    // A write presented while reset is low is ignored.
    drive(1'b1, 5'd5, 32'h00000001, 5'd5, 5'd9);
    tick();
    #2;
    // First edge after deassertion accepts its write.
    drive(1'b1, 5'd9, 32'h00000099, 5'd5, 5'd0);
    reset = 1'b1;
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd5);
    #1;
    check("post_reset_r9", c_rd1, 32'h00000099);
    check("write_in_reset_lost", c_rd2, 32'h0);
    check("post_reset_cnt", {16'h0, c_cnt}, 32'd1);

    // Full sweep: r1..r31 = 0x100+i, then pairs (i, 32-i).
    do_reset();
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 5'(i), 32'h100 + 32'(i), 5'd0, 5'd0);
      tick();
    end
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    #1;
    check("sweep_cnt", {16'h0, c_cnt}, 32'd31);
    for (int i = 1; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(32 - i));
      #1;
      check($sformatf("sweep_comb_rd1_r%0d", i), c_rd1, 32'h100 + 32'(i));
      check($sformatf("sweep_comb_rd2_r%0d", 32 - i), c_rd2, 32'h100 + 32'(32 - i));
      tick();
      check($sformatf("sweep_sync_rd1_r%0d", i), s_rd1, 32'h100 + 32'(i));
      check($sformatf("sweep_sync_rd2_r%0d", 32 - i), s_rd2, 32'h100 + 32'(32 - i));
    end

    // Same-cycle bypass on both ports.
    drive(1'b1, 5'd7, 32'h1111, 5'd0, 5'd0);
    tick();
    drive(1'b1, 5'd7, 32'h2222, 5'd7, 5'd7);
    #1;
    check("bypass_pre_rd1", c_rd1, 32'h2222);
    check("bypass_pre_rd2", c_rd2, 32'h2222);
    tick();
    check("bypass_sync_rd1", s_rd1, 32'h2222);
    check("bypass_sync_rd2", s_rd2, 32'h2222);
    regWrite = 1'b0;
    #1;
    check("bypass_post_rd1", c_rd1, 32'h2222);
    check("bypass_post_rd2", c_rd2, 32'h2222);

    // Registered read with stall.
    drive(1'b1, 5'd3, 32'hA5A5, 5'd0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
    readEn = 1'b1;
    tick();
    check("stall_latch", s_rd1, 32'hA5A5);
    readEn = 1'b0;
    drive(1'b1, 5'd3, 32'h5A5A, 5'd3, 5'd3);
    tick();
    check("stall_hold_1", s_rd1, 32'hA5A5);
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
    tick();
    check("stall_hold_2", s_rd2, 32'hA5A5);
    check("stall_comb_new", c_rd1, 32'h5A5A);
    readEn = 1'b1;
    tick();
    check("stall_release", s_rd1, 32'h5A5A);

    // Saturation of the write counter.
    do_reset();
    for (int i = 0; i < 65534; i++) begin
      drive(1'b1, 5'((i % 31) + 1), 32'(i), 5'd0, 5'd0);
      tick();
    end
    check("sat_fffe", {16'h0, c_cnt}, 32'h0000FFFE);
    tick();
    check("sat_ffff", {16'h0, c_cnt}, 32'h0000FFFF);
    for (int i = 0; i < 5; i++) begin
      tick();
    end
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    #1;
    check("sat_hold_comb", {16'h0, c_cnt}, 32'h0000FFFF);
    check("sat_hold_sync", {16'h0, s_cnt}, 32'h0000FFFF);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/regfile32.md
# regfile32

Register file for the pipelined MIPS datapath: 32 registers of 32 bits, one write port and two read ports. The write port is the one-to-many counterpart of the datapath's 32-bit selection muxes: a single writeback word is steered to one of 32 destinations. It sits between the ID stage (reads rs/rt) and the WB stage (writes rd/rt). It adds write-through bypass and a hardwired zero register.

## Interface
Parameters:
- DATA_W, 32, register width.
- ADDR_W, 5, register index width; depth is 2**ADDR_W.
- SYNC_READ, 0, read mode. 0 = combinational read ports; 1 = read data registered on the rising clock edge.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low. Clears all registers and read outputs while low.
- regWrite  input  1  write enable for the write port.
- writeReg  input  ADDR_W  destination register index.
- writeData  input  DATA_W  word to write.
- readReg1  input  ADDR_W  read port 1 index (rs).
- readReg2  input  ADDR_W  read port 2 index (rt).
- readEn  input  1  read strobe. Used only when SYNC_READ=1; low holds the outputs (ID stall).
- readData1  output  DATA_W  read port 1 data.
- readData2  output  DATA_W  read port 2 data.
- writeCount  output  16  count of accepted writes, saturating at 16'hFFFF. Debug/verification aid.

## Operation
- Storage: registers 1..31 are writable. Register 0 reads 0 in every mode; writes to it are discarded and do not increment writeCount.
- Write decode: when regWrite=1 and writeReg!=0, the register at writeReg takes writeData at the rising edge. All other registers hold. Exactly one register changes per accepted write.
- writeCount: increments by 1 on each accepted write, i.e. regWrite=1 and writeReg!=0. It saturates at 16'hFFFF and never wraps.
- Read, SYNC_READ=0:
  - readDataN = 0 if readRegN=0.
  - Otherwise, if regWrite=1 and writeReg=readRegN, readDataN = writeData (write-through bypass, same cycle).
  - Otherwise readDataN = stored value.
  - This lets WB write and ID read in the same cycle without a forwarding stall.
- Read, SYNC_READ=1:
  - On a rising edge with readEn=1, readDataN captures the same value the combinational path would produce in that cycle, bypass included.
  - With readEn=0, readDataN holds its previous value.
  - A register updated by a write in a later cycle does not change held outputs.
- Both read ports are independent. They may address the same register, and may also address writeReg, simultaneously.
- Reset (reset=0, asynchronous):
  - All 31 writable registers, readData1/2 (registered mode) and writeCount go to 0 immediately, with no clock required.
  - In combinational mode readDataN reflect the cleared storage, so they read 0.
  - Writes presented while reset=0 are ignored.
- Reset deassertion: the first edge after reset rises behaves normally. A write at that edge is accepted.

## Timing
- Write latency: 1 edge. Data appears in storage after the rising edge at which regWrite=1.
- Read latency:
  - SYNC_READ=0: combinational; bypass has zero cycles of delay.
  - SYNC_READ=1: 1 cycle from address/readEn to output.
- Write-to-read of same index:
  - SYNC_READ=0: visible in the same cycle (bypass).
  - SYNC_READ=1: visible at the same edge that performs the write.
- Reset mid-operation: outputs are 0 within the reset assertion, independent of clock. Any in-flight write at a coincident edge is lost.
- No X propagation: every output is a defined value from reset onward. Unwritten registers read 0.

## Test plan
- Reset clear: write 32'hDEADBEEF to r5, then pulse reset low mid-cycle -> readData1 (readReg1=5) = 0 without a clock edge; writeCount = 0.
- Zero register: regWrite=1, writeReg=0, writeData=32'hFFFFFFFF; then read readReg1=0 -> readData1=0, writeCount unchanged.
- Full sweep: write r1..r31 with value 32'h100+i, then read all pairs (i, 32-i) -> each port returns its own value; writeCount=31.
- Same-cycle bypass (SYNC_READ=0): r7 holds 32'h1111. Drive regWrite=1, writeReg=7, writeData=32'h2222 with readReg1=readReg2=7 -> both outputs read 32'h2222 before the edge and after it.
- Registered read with stall (SYNC_READ=1): readEn=1 on r3=32'hA5A5 latches A5A5. Then readEn=0 while r3 is written with 32'h5A5A -> output stays A5A5. readEn=1 at the next edge -> 5A5A.
- Saturation: force 65 540 accepted writes -> writeCount holds 16'hFFFF and never returns to 0.
